// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, one bit per clock, LSB first.
// A full-adder slice built from two half-adder stages plus a carry OR
// consumes one bit of each operand per cycle, with a registered carry.
//
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   START  request; operands are captured when it is accepted in IDLE or FIN
//   A, B   WIDTH-bit operands
//   BUSY   high while an addition is in progress (state ADD)
//   DONE   one-cycle pulse marking S/COUT valid (state FIN)
//   S      registered WIDTH-bit sum, held until the next completion
//   COUT   registered carry-out, held until the next completion
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Full-adder slice on the current LSBs: two half-adder stages plus carry OR.
  logic             ha1_s, ha1_c, ha2_c;
  logic             sb_c, carry_nxt_c;
  logic [WIDTH-1:0] rs_nxt_c;

  always_comb begin
    ha1_s       = ra_q[0] ^ rb_q[0];
    ha1_c       = ra_q[0] & rb_q[0];
    sb_c        = ha1_s ^ c_q;
    ha2_c       = ha1_s & c_q;
    carry_nxt_c = ha1_c | ha2_c;
    // Sum bit enters at the MSB; after WIDTH shifts rs holds the sum LSB-aligned.
    rs_nxt_c    = (rs_q >> 1) | (WIDTH'(sb_c) << (WIDTH - 1));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          ra_d    = A;
          rb_d    = B;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        rs_d  = rs_nxt_c;
        c_d   = carry_nxt_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          s_d     = rs_nxt_c;
          cout_d  = carry_nxt_c;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        // Back-to-back: a new request is loaded exactly as from IDLE.
        if (START) begin
          ra_d    = A;
          rb_d    = B;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ADD);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign S    = s_q;
  assign COUT = cout_q;

endmodule
